// File: rtl/spi_slave_port_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_port_pkg
// Shared definitions for the SPI slave endpoint: default word width and
// synchronizer depth, register-port addresses, and the status/control flag
// layout (bits [8:3] of the status and control registers).
// -----------------------------------------------------------------------------
package spi_slave_port_pkg;

    localparam int DATABITS_DEFAULT    = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Register-port addresses
    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    // Bit positions of the flags inside status/control
    localparam int BIT_E    = 8;
    localparam int BIT_RRDY = 7;
    localparam int BIT_TRDY = 6;
    localparam int BIT_TUR  = 5;
    localparam int BIT_TOE  = 4;
    localparam int BIT_ROE  = 3;

    // Field order matches bits [8:3]: e lands on bit 8, roe on bit 3.
    typedef struct packed {
        logic e;
        logic rrdy;
        logic trdy;
        logic tur;
        logic toe;
        logic roe;
    } flags_t;

    // Place a flag set into its 16-bit register image; unused bits read 0.
    function automatic logic [15:0] pack_flags(input flags_t f);
        return {7'b0, f, 3'b0};
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
// Brings the asynchronous SPI pins into the clk domain and derives one-cycle
// edge pulses from the synchronized SCLK and SS_n.
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   sclk, ss_n, mosi      raw SPI pins from the master
//   sclk_rise, sclk_fall  1-clk pulses on synced SCLK edges
//   ss_fall, ss_rise      1-clk pulses on synced SS_n edges (frame start/end)
//   ss_active             synced SS_n is low
//   mosi_s                synced MOSI, same latency as SCLK
// -----------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_active,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] ss_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sclk_d;
    logic                   ss_d;

    // SS_n resets to its idle (high) level so reset never fakes a frame start.
    // NOTE: state is updated with non-blocking assignments so every flop in the
    // chain samples the previous-cycle value, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_pipe <= '0;
            ss_pipe   <= '1;
            mosi_pipe <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_pipe[SYNC_STAGES-1];
            ss_d      <= ss_pipe[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_pipe[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_pipe[SYNC_STAGES-1] & sclk_d;
    assign ss_fall   = ~ss_pipe[SYNC_STAGES-1] & ss_d;
    assign ss_rise   = ss_pipe[SYNC_STAGES-1] & ~ss_d;
    assign ss_active = ~ss_pipe[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_port.sv
// -----------------------------------------------------------------------------
// spi_slave_port
// SPI mode-0, LSB-first slave endpoint with a single-cycle CPU register port.
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   SCLK, SS_n, MOSI    SPI inputs from the master (asynchronous)
//   MISO, MISO_oe       serial data to the master and its output enable
//   spi_select, mem_addr, read_n, write_n, data_from_cpu
//                       register port request (0 rxdata, 1 txdata,
//                       2 status, 3 control)
//   data_to_cpu         registered read data
//   irq                 registered interrupt: any enabled status flag
//   dataavailable       RRDY
//   readyfordata        TRDY
// -----------------------------------------------------------------------------
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int DATABITS    = DATABITS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam int                CNT_W    = $clog2(DATABITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATABITS - 1);

    // Synchronized pin events
    logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_active, mosi_s;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (SCLK),
        .ss_n      (SS_n),
        .mosi      (MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .ss_active (ss_active),
        .mosi_s    (mosi_s)
    );

    // Datapath state
    logic [DATABITS-1:0] rx_shift, rx_holding;
    logic [DATABITS-1:0] tx_shift, tx_holding;
    logic [CNT_W-1:0]    bitcnt;
    logic                primed;
    logic                ur_pending;
    logic                oe_q;

    // Status / control state
    logic   rrdy, tur, toe, roe;
    flags_t ctrl_q;
    flags_t status_flags;

    // Register-port decode
    logic wr_en, rd_en, wr_tx, wr_status, wr_ctrl, rd_rx;
    assign wr_en     = spi_select & ~write_n;
    assign rd_en     = spi_select & ~read_n;
    assign wr_tx     = wr_en & (mem_addr == ADDR_TXDATA);
    assign wr_status = wr_en & (mem_addr == ADDR_STATUS);
    assign wr_ctrl   = wr_en & (mem_addr == ADDR_CONTROL);
    assign rd_rx     = rd_en & (mem_addr == ADDR_RXDATA);

    // SPI events; a frame start takes priority over any SCLK edge that
    // coincides with it, and edges outside a frame are dropped.
    logic frame_start, rise_ev, fall_ev, boundary_load, load_now, word_done;
    logic tx_accept;
    logic [DATABITS-1:0] rx_word;

    assign frame_start   = ss_fall;
    assign rise_ev       = sclk_rise & ss_active & ~ss_fall;
    assign fall_ev       = sclk_fall & ss_active & ~ss_fall;
    assign boundary_load = fall_ev & (bitcnt == '0);
    assign load_now      = frame_start | boundary_load;
    assign word_done     = rise_ev & (bitcnt == LAST_BIT);
    assign rx_word       = {mosi_s, rx_shift[DATABITS-1:1]};
    // A write that lands in the same cycle as a shift load is accepted: the
    // load consumes the old holding value and the write re-primes it.
    assign tx_accept     = wr_tx & (~primed | load_now);

    // Shift registers, bit counter and output enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift   <= '0;
            tx_shift   <= '0;
            bitcnt     <= '0;
            ur_pending <= 1'b0;
            oe_q       <= 1'b0;
        end else if (!ss_active) begin
            // Between frames: any partial rx word is abandoned.
            bitcnt     <= '0;
            ur_pending <= 1'b0;
            oe_q       <= 1'b0;
        end else if (frame_start) begin
            bitcnt     <= '0;
            oe_q       <= 1'b1;
            ur_pending <= 1'b0;
            tx_shift   <= primed ? tx_holding : '0;
        end else begin
            if (rise_ev) begin
                rx_shift   <= rx_word;
                bitcnt     <= word_done ? '0 : bitcnt + CNT_W'(1);
                ur_pending <= 1'b0;
            end
            if (fall_ev) begin
                if (bitcnt != '0) begin
                    tx_shift <= tx_shift >> 1;
                end else begin
                    // Word boundary. Mode 0 always ends on a trailing SCLK fall,
                    // so an empty holding register only counts as an underrun
                    // once the master actually clocks the next word.
                    tx_shift   <= primed ? tx_holding : '0;
                    ur_pending <= ~primed;
                end
            end
        end
    end

    // Holding registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_holding <= '0;
            rx_holding <= '0;
            primed     <= 1'b0;
        end else begin
            if (load_now)  primed <= 1'b0;
            if (tx_accept) begin
                tx_holding <= data_from_cpu[DATABITS-1:0];
                primed     <= 1'b1;
            end
            if (word_done) rx_holding <= rx_word;
        end
    end

    // Status flags: clears come first so a set in the same cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rrdy <= 1'b0;
            tur  <= 1'b0;
            toe  <= 1'b0;
            roe  <= 1'b0;
        end else begin
            if (wr_status) begin
                rrdy <= 1'b0;
                tur  <= 1'b0;
                toe  <= 1'b0;
                roe  <= 1'b0;
            end
            if (rd_rx) rrdy <= 1'b0;
            if (word_done) begin
                rrdy <= 1'b1;
                if (rrdy) roe <= 1'b1;
            end
            if (frame_start && !primed)               tur <= 1'b1;
            if (rise_ev && bitcnt == '0 && ur_pending) tur <= 1'b1;
            if (wr_tx && !tx_accept)                   toe <= 1'b1;
        end
    end

    assign status_flags = '{
        e:    roe | toe | tur,
        rrdy: rrdy,
        trdy: ~primed,
        tur:  tur,
        toe:  toe,
        roe:  roe
    };

    // Read mux
    logic [15:0] rd_mux;

    // NOTE: every path of a combinational block must assign its outputs; the
    // default at the top prevents a latch for addresses the case misses.
    always_comb begin
        rd_mux = '0;
        unique case (mem_addr)
            ADDR_RXDATA:  rd_mux = 16'(rx_holding);
            ADDR_STATUS:  rd_mux = pack_flags(status_flags);
            ADDR_CONTROL: rd_mux = pack_flags(ctrl_q);
            default:      rd_mux = '0;
        endcase
    end

    // Control register, read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= flags_t'(data_from_cpu[BIT_E:BIT_ROE]);
            if (rd_en)   data_to_cpu <= rd_mux;
            irq <= |(status_flags & ctrl_q);
        end
    end

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^data_from_cpu[15:BIT_E+1];

    assign MISO          = oe_q & tx_shift[0];
    assign MISO_oe       = oe_q;
    assign dataavailable = rrdy;
    assign readyfordata  = ~primed;

    // Any unused_wdata reference above keeps lint quiet about bits [15:9];
    // ss_rise is implied by ss_active going low and needs no separate action.
    logic unused_ss_rise;
    assign unused_ss_rise = ss_rise;

endmodule

// File: tb/tb_spi_slave_port.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_port
// Directed bench for spi_slave_port: a mode-0, LSB-first SPI master model with
// SCLK = clk/16, CPU register read/write tasks, and hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_spi_slave_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        MISO_oe;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = 3'd0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] data_from_cpu = 16'h0000;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam time HALF_SCLK = 80ns;   // 8 clk periods per SCLK phase

    spi_slave_port dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .SCLK          (SCLK),
        .SS_n          (SS_n),
        .MOSI          (MOSI),
        .MISO          (MISO),
        .MISO_oe       (MISO_oe),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .irq           (irq),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata)
    );

    always #5ns clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        spi_select    = 1'b1;
        write_n       = 1'b0;
        mem_addr      = addr;
        data_from_cpu = data;
        @(negedge clk);
        spi_select    = 1'b0;
        write_n       = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] addr, output logic [15:0] data);
        @(negedge clk);
        spi_select = 1'b1;
        read_n     = 1'b0;
        mem_addr   = addr;
        @(negedge clk);
        spi_select = 1'b0;
        read_n     = 1'b1;
        data       = data_to_cpu;
    endtask

    // One SS_n-framed transfer of nbits, LSB first. MISO is sampled just
    // before each SCLK rise; oe_seen is MISO_oe at the first sample.
    task automatic spi_xfer(input logic [15:0] mosi_word, input int nbits,
                            output logic [15:0] miso_word, output logic oe_seen);
        miso_word = '0;
        oe_seen   = 1'b0;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mosi_word[i];
            #(HALF_SCLK);
            miso_word[i] = MISO;
            if (i == 0) oe_seen = MISO_oe;
            SCLK = 1'b1;
            #(HALF_SCLK);
            SCLK = 1'b0;
        end
        #(HALF_SCLK);
        SS_n = 1'b1;
        #(HALF_SCLK);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic [15:0] miso_w;
        logic        oe;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_miso",    16'(MISO),          16'h0);
        check("rst_oe",      16'(MISO_oe),       16'h0);
        check("rst_rdata",   data_to_cpu,        16'h0);
        check("rst_irq",     16'(irq),           16'h0);
        check("rst_rrdy",    16'(dataavailable), 16'h0);
        check("rst_trdy",    16'(readyfordata),  16'h1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- 1: preload 0xA5, receive 0x3C ----------------
        cpu_write(3'd1, 16'h00A5);
        check("t1_trdy_low", 16'(readyfordata), 16'h0);
        spi_xfer(16'h003C, 8, miso_w, oe);
        check("t1_miso",     miso_w, 16'h00A5);
        check("t1_oe",       16'(oe), 16'h1);
        check("t1_rrdy_pin", 16'(dataavailable), 16'h1);
        cpu_read(3'd2, rd);
        check("t1_status",   rd, 16'h00C0);
        cpu_read(3'd0, rd);
        check("t1_rxdata",   rd, 16'h003C);
        cpu_read(3'd2, rd);
        check("t1_status_after_read", rd, 16'h0040);

        // ---------------- 2: no preload -> underrun ----------------
        cpu_write(3'd3, 16'h0020);
        cpu_read(3'd3, rd);
        check("t2_control",  rd, 16'h0020);
        spi_xfer(16'h0011, 8, miso_w, oe);
        check("t2_miso",     miso_w, 16'h0000);
        cpu_read(3'd2, rd);
        check("t2_status",   rd, 16'h01E0);
        check("t2_irq",      16'(irq), 16'h1);
        cpu_write(3'd2, 16'h0000);
        check("t2_irq_lag",  16'(irq), 16'h1);
        @(negedge clk);
        check("t2_irq_clr",  16'(irq), 16'h0);
        cpu_read(3'd2, rd);
        check("t2_status_clr", rd, 16'h0040);

        // ---------------- 3: two words, no read -> overrun ----------------
        cpu_write(3'd3, 16'h0008);
        cpu_write(3'd1, 16'h0096);
        spi_xfer(16'h5AC3, 16, miso_w, oe);
        check("t3_miso",     miso_w, 16'h0096);
        cpu_read(3'd2, rd);
        check("t3_status",   rd, 16'h01E8);
        check("t3_irq",      16'(irq), 16'h1);
        cpu_read(3'd0, rd);
        check("t3_rxdata",   rd, 16'h005A);
        cpu_write(3'd2, 16'h0000);
        @(negedge clk);
        check("t3_irq_clr",  16'(irq), 16'h0);
        cpu_read(3'd2, rd);
        check("t3_status_clr", rd, 16'h0040);

        // ---------------- 4: double tx write -> TOE ----------------
        cpu_write(3'd3, 16'h0010);
        cpu_write(3'd1, 16'h005A);
        cpu_write(3'd1, 16'h0077);
        cpu_read(3'd2, rd);
        check("t4_status",   rd, 16'h0110);
        check("t4_irq",      16'(irq), 16'h1);
        spi_xfer(16'h0000, 8, miso_w, oe);
        check("t4_miso",     miso_w, 16'h005A);
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0000);

        // ---------------- 5: partial word, then 0x81 ----------------
        spi_xfer(16'h000F, 4, miso_w, oe);
        check("t5_no_rrdy",  16'(dataavailable), 16'h0);
        check("t5_oe_idle",  16'(MISO_oe), 16'h0);
        cpu_read(3'd2, rd);
        check("t5_status",   rd, 16'h0160);
        spi_xfer(16'h0081, 8, miso_w, oe);
        cpu_read(3'd0, rd);
        check("t5_rxdata",   rd, 16'h0081);
        check("t5_oe_idle2", 16'(MISO_oe), 16'h0);

        // ---------------- 6: reset mid-frame ----------------
        cpu_write(3'd3, 16'h0020);          // TUR is still set from test 5
        @(negedge clk);
        check("t6_irq_pre",  16'(irq), 16'h1);
        cpu_write(3'd1, 16'h00FF);
        @(negedge clk);
        SS_n = 1'b0;
        #(HALF_SCLK);
        check("t6_miso_pre", 16'(MISO), 16'h1);
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1;
            #(HALF_SCLK);
            SCLK = 1'b0;
            #(HALF_SCLK);
        end
        #3ns;
        reset_n = 1'b0;
        #2ns;
        check("t6_miso",     16'(MISO),          16'h0);
        check("t6_oe",       16'(MISO_oe),       16'h0);
        check("t6_rdata",    data_to_cpu,        16'h0);
        check("t6_irq",      16'(irq),           16'h0);
        check("t6_rrdy",     16'(dataavailable), 16'h0);
        check("t6_trdy",     16'(readyfordata),  16'h1);
        SS_n = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        cpu_read(3'd2, rd);
        check("t6_status",   rd, 16'h0040);
        cpu_write(3'd1, 16'h003C);
        spi_xfer(16'h00A7, 8, miso_w, oe);
        check("t6_miso_post", miso_w, 16'h003C);
        cpu_read(3'd0, rd);
        check("t6_rxdata",   rd, 16'h00A7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
